// File: rtl/la_packet_decoder_mc.sv
// -----------------------------------------------------------------------------
// la_packet_decoder_mc
//
// Multi-lane packet framer/decoder for the logic-analyser receive path.
// It takes one deserialised word per clock. The word's MSB is a start marker
// and the remaining bits are beat data. BEATS beats are assembled into one
// packet, beat 1 most significant. Frame lock is tracked with a
// consecutive-good-packet counter. Completed packets are emitted with a
// one-cycle valid strobe once lock is held. Framing errors are counted in a
// saturating counter.
//
// Optional feature: define LA_CRC_CHECK_EN to check a CRC-8 (poly 0x07,
// init 0x00, MSB first) carried in payload[7:0]. A mismatching packet is
// dropped and counted as an error. A matching packet is emitted with
// payload[7:0] cleared.
//
// Ports:
//   clk          rx pixel clock, rising edge
//   rst_n        asynchronous active-low reset
//   rxd          deserialised word: rxd[WW-1] = start marker, rxd[W-1:0] = data
//   err_clr      synchronous clear of err_count
//   packet_type  type field of the last emitted packet
//   payload      payload of the last emitted packet
//   valid        single-cycle strobe: packet_type/payload are new this cycle
//   locked       frame lock
//   err_count    saturating framing/CRC error count
// -----------------------------------------------------------------------------
module la_packet_decoder_mc #(
    parameter int LANES      = 4,
    parameter int BEATS      = 2,
    parameter int TYPE_BITS  = 6,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_BITS   = 16,
    localparam int WW           = 7 * LANES,
    localparam int W            = WW - 1,
    localparam int PKT_BITS     = W * BEATS,
    localparam int PAYLOAD_BITS = PKT_BITS - TYPE_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WW-1:0]           rxd,
    input  logic                    err_clr,
    output logic [TYPE_BITS-1:0]    packet_type,
    output logic [PAYLOAD_BITS-1:0] payload,
    output logic                    valid,
    output logic                    locked,
    output logic [ERR_BITS-1:0]     err_count
);

    localparam int IDX_W  = $clog2(BEATS + 1);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;      // index of the beat expected next
    logic [PKT_BITS-1:0]     acc_q, acc_d;
    logic [GOOD_W-1:0]       good_q, good_d;
    logic                    locked_q, locked_d;
    logic                    valid_q, valid_d;
    logic [TYPE_BITS-1:0]    type_q, type_d;
    logic [PAYLOAD_BITS-1:0] pay_q, pay_d;
    logic [ERR_BITS-1:0]     err_q, err_d;

    logic                    start;
    logic                    take_beat;
    logic                    last_beat;
    logic                    frame_err;
    logic                    crc_ok;
    logic                    err_event;
    logic [PKT_BITS-1:0]     data_ext;
    logic [PKT_BITS-1:0]     assembled;

    assign start = rxd[WW-1];

`ifdef LA_CRC_CHECK_EN
    // CRC-8, poly x^8+x^2+x+1, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8(input logic [PKT_BITS-9:0] bits);
        logic [7:0] crc;
        logic       fb;
        crc = 8'h00;
        for (int i = PKT_BITS - 9; i >= 0; i--) begin
            fb  = crc[7] ^ bits[i];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return crc;
    endfunction
`endif

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        take_beat = 1'b0;
        last_beat = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    take_beat = 1'b1;
                    if (BEATS == 1) begin
                        last_beat = 1'b1;
                    end else begin
                        state_d = COLLECT;
                        idx_d   = IDX_W'(2);
                    end
                end
            end
            COLLECT: begin
                take_beat = 1'b1;
                if (start) begin
                    // Marker mid-packet: drop the partial packet and restart
                    // with this word as beat 1.
                    frame_err = 1'b1;
                    idx_d     = IDX_W'(2);
                end else if (idx_q == IDX_W'(BEATS)) begin
                    last_beat = 1'b1;
                    state_d   = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath / output logic
    // ---------------------------------------------------------------------
    always_comb begin
        data_ext         = '0;
        data_ext[W-1:0]  = rxd[W-1:0];
        // After BEATS shifts the stale contents have left the register, so
        // the accumulator never needs clearing at the start of a packet.
        assembled        = (acc_q << W) | data_ext;
        acc_d            = take_beat ? assembled : acc_q;

`ifdef LA_CRC_CHECK_EN
        crc_ok = (crc8(assembled[PKT_BITS-1:8]) == assembled[7:0]);
`else
        crc_ok = 1'b1;
`endif

        good_d    = good_q;
        locked_d  = locked_q;
        valid_d   = 1'b0;
        type_d    = type_q;
        pay_d     = pay_q;
        err_event = 1'b0;

        if (frame_err) begin
            err_event = 1'b1;
            good_d    = '0;
            locked_d  = 1'b0;
        end else if (last_beat) begin
            if (!crc_ok) begin
                err_event = 1'b1;
            end else begin
                if (good_q != GOOD_W'(LOCK_COUNT)) begin
                    good_d = good_q + 1'b1;
                end
                if (good_d == GOOD_W'(LOCK_COUNT)) begin
                    locked_d = 1'b1;
                end
                // Emit only once lock holds after this packet is counted.
                if (locked_d) begin
                    valid_d = 1'b1;
                    type_d  = assembled[PKT_BITS-1 -: TYPE_BITS];
                    pay_d   = assembled[PAYLOAD_BITS-1:0];
`ifdef LA_CRC_CHECK_EN
                    pay_d[7:0] = 8'h00;
`endif
                end
            end
        end

        // A clear coinciding with an error still records that error.
        if (err_clr) begin
            err_d = err_event ? ERR_BITS'(1) : '0;
        end else if (err_event && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
            type_q   <= '0;
            pay_q    <= '0;
            err_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            valid_q  <= valid_d;
            type_q   <= type_d;
            pay_q    <= pay_d;
            err_q    <= err_d;
        end
    end

    assign packet_type = type_q;
    assign payload     = pay_q;
    assign valid       = valid_q;
    assign locked      = locked_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_la_packet_decoder_mc.sv
// -----------------------------------------------------------------------------
// tb_la_packet_decoder_mc
//
// Directed bench for la_packet_decoder_mc with default parameters
// (28-bit words, 2 beats, 6-bit type, 48-bit payload, lock after 4).
// Expected packets are queued when their last beat is driven and popped
// when the output is sampled one cycle later.
// -----------------------------------------------------------------------------
module tb_la_packet_decoder_mc;

    logic        clk;
    logic        rst_n;
    logic [27:0] rxd;
    logic        err_clr;
    logic [5:0]  packet_type;
    logic [47:0] payload;
    logic        valid;
    logic        locked;
    logic [15:0] err_count;

    int n_asserts;
    int n_fail;

    logic [53:0] sb[$];

`ifdef LA_CRC_CHECK_EN
    // All-zero packets carry CRC 0x00, which is a correct CRC.
    localparam logic [5:0]  T1 = 6'h00;
    localparam logic [47:0] P1 = 48'h0;
    localparam logic [5:0]  T2 = 6'h00;
    localparam logic [47:0] P2 = 48'h0;
    localparam int          E0 = 1;     // err_count before the saturation step
`else
    localparam logic [5:0]  T1 = 6'h15;
    localparam logic [47:0] P1 = 48'h1234_5678_9ABC;
    localparam logic [5:0]  T2 = 6'h2A;
    localparam logic [47:0] P2 = 48'hFEDC_BA98_7654;
    localparam int          E0 = 0;
`endif

    la_packet_decoder_mc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .err_clr     (err_clr),
        .packet_type (packet_type),
        .payload     (payload),
        .valid       (valid),
        .locked      (locked),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output check for the cycle just clocked: valid must match whether a
    // packet was expected, and an expected packet must match the outputs.
    task automatic check_cycle();
        logic [53:0] e;
        logic        exp_v;
        exp_v = (sb.size() != 0);
        chk("valid", valid, exp_v);
        if (exp_v) begin
            e = sb.pop_front();
            chk("packet_type", packet_type, e[53:48]);
            chk("payload", payload, e[47:0]);
        end
    endtask

    // Drive a word on the falling edge, then sample 1 time unit after the
    // rising edge that captures it.
    task automatic drive_word(input logic s, input logic [26:0] d,
                              input logic clr, input logic do_check);
        @(negedge clk);
        rxd     = {s, d};
        err_clr = clr;
        @(posedge clk);
        #1;
        if (do_check) check_cycle();
    endtask

    function automatic logic [26:0] beat1(input logic [5:0] t, input logic [47:0] p);
        logic [53:0] pk;
        pk = {t, p};
        return pk[53:27];
    endfunction

    function automatic logic [26:0] beat2(input logic [5:0] t, input logic [47:0] p);
        logic [53:0] pk;
        pk = {t, p};
        return pk[26:0];
    endfunction

    task automatic send_pkt(input logic [5:0] t, input logic [47:0] p, input logic emit);
        drive_word(1'b1, beat1(t, p), 1'b0, 1'b1);
        if (emit) sb.push_back({t, p});
        drive_word(1'b0, beat2(t, p), 1'b0, 1'b1);
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        rxd       = '0;
        err_clr   = 1'b0;

        // Reset state.
        #12;
        chk("rst_valid", valid, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_type", packet_type, 6'h0);
        chk("rst_payload", payload, 48'h0);
        chk("rst_err", err_count, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Acquire lock: packets 1-3 silent, packet 4 emitted with locked.
        for (int i = 0; i < 3; i++) begin
            send_pkt(T1, P1, 1'b0);
            chk("prelock_locked", locked, 1'b0);
        end
        send_pkt(T1, P1, 1'b1);
        chk("lock_locked", locked, 1'b1);
        chk("lock_err", err_count, 16'h0);

        // Framing error: marker on beat 2 starts a new packet.
        drive_word(1'b1, beat1(T1, P1), 1'b0, 1'b1);
        drive_word(1'b1, beat1(T2, P2), 1'b0, 1'b1);
        chk("ferr_err", err_count, 16'h1);
        chk("ferr_locked", locked, 1'b0);
        drive_word(1'b0, beat2(T2, P2), 1'b0, 1'b1);   // good packet 1
        send_pkt(T2, P2, 1'b0);
        send_pkt(T2, P2, 1'b0);
        chk("relock_pending", locked, 1'b0);
        send_pkt(T2, P2, 1'b1);                        // good packet 4
        chk("relock_locked", locked, 1'b1);

        // Idle words between packets, then back-to-back packets.
        for (int i = 0; i < 3; i++) drive_word(1'b0, 27'h5A5A5A5, 1'b0, 1'b1);
        chk("idle_err", err_count, 16'h1);
        send_pkt(T1, P1, 1'b1);
        send_pkt(T2, P2, 1'b1);
        chk("b2b_locked", locked, 1'b1);

        // Reset mid-packet clears outputs immediately.
        drive_word(1'b1, beat1(T1, P1), 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_locked", locked, 1'b0);
        chk("mid_rst_type", packet_type, 6'h0);
        chk("mid_rst_payload", payload, 48'h0);
        chk("mid_rst_err", err_count, 16'h0);
        chk("mid_rst_valid", valid, 1'b0);
        #1;
        rst_n = 1'b1;
        // First S=0 word after reset is idle, not a beat 2.
        drive_word(1'b0, beat2(T1, P1), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_pkt(T2, P2, 1'b0);
        send_pkt(T2, P2, 1'b1);
        chk("post_rst_locked", locked, 1'b1);

`ifdef LA_CRC_CHECK_EN
        // Good CRC emitted; bad CRC dropped without losing lock.
        send_pkt(6'h00, 48'h0, 1'b1);
        send_pkt(6'h00, 48'h1, 1'b0);
        chk("crc_err", err_count, 16'h1);
        chk("crc_locked", locked, 1'b1);
`endif

        // Saturation: repeated markers are one error each after the first.
        drive_word(1'b1, 27'h0, 1'b0, 1'b1);
        for (int i = 0; i < 65535 - E0; i++) drive_word(1'b1, 27'h0, 1'b0, 1'b0);
        chk("sat_reach", err_count, 16'hFFFF);
        drive_word(1'b1, 27'h0, 1'b0, 1'b1);
        chk("sat_hold", err_count, 16'hFFFF);
        chk("sat_locked", locked, 1'b0);
        drive_word(1'b1, 27'h0, 1'b1, 1'b1);
        chk("clr_with_err", err_count, 16'h1);
        drive_word(1'b0, 27'h0, 1'b0, 1'b1);           // completes, not locked
        chk("clr_hold", err_count, 16'h1);
        drive_word(1'b0, 27'h0, 1'b1, 1'b1);
        chk("clr_alone", err_count, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
